// File: rtl/sram_mem_arbiter_pkg.sv
// Shared widths, FSM state encoding and owner tags for the SRAM arbiter.
// Imported by the interface, the arbiter top and its testbench.
package sram_mem_arbiter_pkg;

  localparam int PC_BUS   = 16;
  localparam int INST_BUS = 16;
  localparam int DATA_BUS = 16;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_RD       = 3'd1,
    ARB_WR_SETUP = 3'd2,
    ARB_WR_PULSE = 3'd3,
    ARB_WR_HOLD  = 3'd4,
    ARB_DONE     = 3'd5
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_t;

  // Bits needed to hold a dwell count of n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_mem_arbiter_if.sv
// Pipeline-side request/response signals plus the SRAM pin bundle.
// The arbiter takes the slave view; the pipeline/SRAM side takes the master view.
interface sram_mem_arbiter_if;
  import sram_mem_arbiter_pkg::*;

  logic                if_req;
  logic [PC_BUS-1:0]   if_addr;
  logic [INST_BUS-1:0] if_inst;
  logic                if_valid;

  logic                mem_rd;
  logic                mem_wr;
  logic [15:0]         mem_addr;
  logic [DATA_BUS-1:0] mem_wdata;
  logic [DATA_BUS-1:0] mem_rdata;
  logic                mem_done;

  logic                stall_if;
  logic                stall_mem;

  logic [15:0]         sram_addr;
  logic [DATA_BUS-1:0] sram_dout;
  logic                sram_dout_en;
  logic [DATA_BUS-1:0] sram_din;
  logic                sram_ce_n;
  logic                sram_oe_n;
  logic                sram_we_n;

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, sram_din,
    output if_inst, if_valid, mem_rdata, mem_done, stall_if, stall_mem,
    output sram_addr, sram_dout, sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, sram_din,
    input  if_inst, if_valid, mem_rdata, mem_done, stall_if, stall_mem,
    input  sram_addr, sram_dout, sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing the RD and WR_PULSE dwell periods.
// Holds at zero; zero_o tells the FSM the dwell has elapsed.
module sram_wait_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_mem_arbiter.sv
// Arbitrates the single-port SRAM between instruction fetch and the load/store unit.
// MEM (write before read) beats IF; all SRAM strobes and response pulses are registered.
module sram_mem_arbiter #(
  parameter int READ_WAIT = 1,
  parameter int WE_PULSE  = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_mem_arbiter_if.slave  bus
);
  import sram_mem_arbiter_pkg::*;

  localparam int CNT_MAX = (READ_WAIT > WE_PULSE) ? READ_WAIT : WE_PULSE;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_PULSE - 1);

  arb_state_t          state_q;
  arb_owner_t          owner_q;
  logic [15:0]         addr_q;
  logic [DATA_BUS-1:0] dout_q;
  logic                dout_en_q;
  logic                ce_n_q;
  logic                oe_n_q;
  logic                we_n_q;
  logic [INST_BUS-1:0] if_inst_q;
  logic [DATA_BUS-1:0] mem_rdata_q;
  logic                if_valid_q;
  logic                mem_done_q;

  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_load_val;
  logic                cnt_zero;

  // Reloading every IDLE cycle is harmless and arms the read dwell at the grant edge.
  assign cnt_load     = (state_q == ARB_IDLE) || (state_q == ARB_WR_SETUP);
  assign cnt_load_val = (state_q == ARB_IDLE) ? RD_LOAD : WE_LOAD;

  sram_wait_counter #(
    .WIDTH (CNT_W)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      dout_q      <= '0;
      dout_en_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          // mem_wr is checked first, so rd&wr together runs as a write.
          if (bus.mem_wr) begin
            owner_q   <= OWN_MEM;
            addr_q    <= bus.mem_addr;
            dout_q    <= bus.mem_wdata;
            ce_n_q    <= 1'b0;
            dout_en_q <= 1'b1;
            state_q   <= ARB_WR_SETUP;
          end else if (bus.mem_rd) begin
            owner_q <= OWN_MEM;
            addr_q  <= bus.mem_addr;
            ce_n_q  <= 1'b0;
            oe_n_q  <= 1'b0;
            state_q <= ARB_RD;
          end else if (bus.if_req) begin
            owner_q <= OWN_IF;
            addr_q  <= bus.if_addr;
            ce_n_q  <= 1'b0;
            oe_n_q  <= 1'b0;
            state_q <= ARB_RD;
          end
        end
        ARB_RD: begin
          if (cnt_zero) begin
            if (owner_q == OWN_IF) begin
              if_inst_q  <= bus.sram_din;
              if_valid_q <= 1'b1;
            end else begin
              mem_rdata_q <= bus.sram_din;
              mem_done_q  <= 1'b1;
            end
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            state_q <= ARB_DONE;
          end
        end
        ARB_WR_SETUP: begin
          we_n_q  <= 1'b0;
          state_q <= ARB_WR_PULSE;
        end
        ARB_WR_PULSE: begin
          if (cnt_zero) begin
            we_n_q  <= 1'b1;
            state_q <= ARB_WR_HOLD;
          end
        end
        ARB_WR_HOLD: begin
          ce_n_q     <= 1'b1;
          dout_en_q  <= 1'b0;
          mem_done_q <= 1'b1;
          state_q    <= ARB_DONE;
        end
        ARB_DONE: begin
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.sram_addr    = addr_q;
  assign bus.sram_dout    = dout_q;
  assign bus.sram_dout_en = dout_en_q;
  assign bus.sram_ce_n    = ce_n_q;
  assign bus.sram_oe_n    = oe_n_q;
  assign bus.sram_we_n    = we_n_q;
  assign bus.if_inst      = if_inst_q;
  assign bus.if_valid     = if_valid_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.mem_done     = mem_done_q;
  assign bus.stall_if     = bus.if_req & ~if_valid_q;
  assign bus.stall_mem    = (bus.mem_rd | bus.mem_wr) & ~mem_done_q;

endmodule
